race_in_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 8-bit `in` input of the race-test datapath (`top`). It accepts one byte per valid/ready handshake from requester A or B. It drives the accepted byte onto the datapath input for a fixed number of cycles, then returns the bus to an idle value, so stimulus from independent sources never changes `in` on the same clock edge.

---
 rtl/race_pkg.sv | 16 +
 rtl/race_rr_pick.sv | 22 ++
 rtl/race_in_arbiter.sv | 101 ++++++++++
 tb/tb_race_in_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared types and constants for the race-test input arbiter.
// Holds the FSM state enum, dp_src codes and the default idle bus value.
package race_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_A    = 2'b01;
    localparam logic [1:0] SRC_B    = 2'b10;

    localparam logic [7:0] IDLE_VALUE_DEF = 8'h00;

endpackage

// File: rtl/race_rr_pick.sv
// Two-way round-robin picker producing a one-hot grant.
// grant[0] = A, grant[1] = B; ptr = 0 favours A on a tie.
module race_rr_pick (
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    // Tie goes to the requester the pointer names
    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (a_valid && !b_valid):        grant = 2'b01;
            (b_valid && !a_valid):        grant = 2'b10;
            (a_valid && b_valid && !ptr): grant = 2'b01;
            (a_valid && b_valid && ptr):  grant = 2'b10;
            default:                      grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/race_in_arbiter.sv
// Round-robin arbiter/sequencer for the shared datapath input byte.
// Optional macro RACE_ARB_GRANT_CNT_EN adds saturating grant counters.
import race_pkg::*;

module race_in_arbiter #(
    parameter int                DATA_W      = 8,
    parameter int                HOLD_CYCLES = 2,
    parameter logic [DATA_W-1:0] IDLE_VALUE  = DATA_W'(IDLE_VALUE_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [DATA_W-1:0] dp_in,
    output logic [1:0]        dp_src,
    output logic              busy
`ifdef RACE_ARB_GRANT_CNT_EN
    ,
    output logic [15:0]       grant_cnt_a,
    output logic [15:0]       grant_cnt_b
`endif
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    arb_state_e state;
    logic [7:0] hold_cnt;
    logic       rr_ptr;
    logic [1:0] grant;
    logic       idle_ok;
    logic       hs_a;
    logic       hs_b;

    race_rr_pick u_pick (
        .a_valid (a_valid),
        .b_valid (b_valid),
        .ptr     (rr_ptr),
        .grant   (grant)
    );

    // Ready only in IDLE and never while reset is held
    assign idle_ok = rst && (state == ARB_IDLE);
    assign a_ready = idle_ok && grant[0];
    assign b_ready = idle_ok && grant[1];
    assign hs_a    = a_valid && a_ready;
    assign hs_b    = b_valid && b_ready;
    assign busy    = (state == ARB_HOLD);

    // FSM, held byte, hold counter and pointer update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            dp_in    <= IDLE_VALUE;
            dp_src   <= SRC_NONE;
            hold_cnt <= 8'd0;
            rr_ptr   <= 1'b0;
        end else if (state == ARB_IDLE) begin
            if (hs_a || hs_b) begin
                state    <= ARB_HOLD;
                dp_in    <= hs_a ? a_data : b_data;
                dp_src   <= hs_a ? SRC_A : SRC_B;
                hold_cnt <= HOLD_LOAD;
                rr_ptr   <= hs_a;
            end
        end else begin
            if (hold_cnt == 8'd0) begin
                state  <= ARB_IDLE;
                dp_in  <= IDLE_VALUE;
                dp_src <= SRC_NONE;
            end else begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

`ifdef RACE_ARB_GRANT_CNT_EN
    logic [15:0] cnt_a_q;
    logic [15:0] cnt_b_q;

    // Per-requester handshake counters that stick at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_a_q <= 16'd0;
            cnt_b_q <= 16'd0;
        end else begin
            if (hs_a && cnt_a_q != 16'hFFFF)
                cnt_a_q <= cnt_a_q + 16'd1;
            if (hs_b && cnt_b_q != 16'hFFFF)
                cnt_b_q <= cnt_b_q + 16'd1;
        end
    end

    assign grant_cnt_a = cnt_a_q;
    assign grant_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_race_in_arbiter.sv
// Bench for race_in_arbiter: HOLD_CYCLES=2 and =1 instances in lockstep.
// Directed steps then random traffic, checked against a cycle model.
module tb_race_in_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_v [2];
    logic       b_v [2];
    logic [7:0] a_d [2];
    logic [7:0] b_d [2];
    logic       ar  [2];
    logic       br  [2];
    logic [7:0] dp  [2];
    logic [1:0] src [2];
    logic       bsy [2];
`ifdef RACE_ARB_GRANT_CNT_EN
    logic [15:0] gca_o [2];
    logic [15:0] gcb_o [2];
    int          gca   [2];
    int          gcb   [2];
`endif

    int         hl  [2];
    logic [7:0] md  [2];
    logic [1:0] ms  [2];
    bit         fav [2];
    bit         hsa [2];
    bit         hsb [2];
    int         hc  [2];

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    race_in_arbiter #(.HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_v[0]), .a_data(a_d[0]), .a_ready(ar[0]),
        .b_valid(b_v[0]), .b_data(b_d[0]), .b_ready(br[0]),
        .dp_in(dp[0]), .dp_src(src[0]), .busy(bsy[0])
`ifdef RACE_ARB_GRANT_CNT_EN
        , .grant_cnt_a(gca_o[0]), .grant_cnt_b(gcb_o[0])
`endif
    );

    race_in_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_v[1]), .a_data(a_d[1]), .a_ready(ar[1]),
        .b_valid(b_v[1]), .b_data(b_d[1]), .b_ready(br[1]),
        .dp_in(dp[1]), .dp_src(src[1]), .busy(bsy[1])
`ifdef RACE_ARB_GRANT_CNT_EN
        , .grant_cnt_a(gca_o[1]), .grant_cnt_b(gcb_o[1])
`endif
    );

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            hl[i]  = 0;
            md[i]  = 8'h00;
            ms[i]  = 2'b00;
            fav[i] = 1'b0;
            hsa[i] = 1'b0;
            hsb[i] = 1'b0;
`ifdef RACE_ARB_GRANT_CNT_EN
            gca[i] = 0;
            gcb[i] = 0;
`endif
        end
    endtask

    // hl = cycles of data still to be shown, fav = who wins a tie
    task automatic model_check(int i);
        logic       ea;
        logic       eb;
        logic [7:0] edp;
        logic [1:0] esr;
        edp = (hl[i] > 0) ? md[i] : 8'h00;
        esr = (hl[i] > 0) ? ms[i] : 2'b00;
        ea = 1'b0;
        eb = 1'b0;
        if (hl[i] == 0) begin
            if (a_v[i] && (!b_v[i] || !fav[i])) ea = 1'b1;
            else if (b_v[i]) eb = 1'b1;
        end
        check($sformatf("dp_in[%0d]", i), 16'(dp[i]), 16'(edp));
        check($sformatf("dp_src[%0d]", i), 16'(src[i]), 16'(esr));
        check($sformatf("busy[%0d]", i), 16'(bsy[i]), 16'(hl[i] > 0));
        check($sformatf("a_ready[%0d]", i), 16'(ar[i]), 16'(ea));
        check($sformatf("b_ready[%0d]", i), 16'(br[i]), 16'(eb));
`ifdef RACE_ARB_GRANT_CNT_EN
        check($sformatf("gcnt_a[%0d]", i), gca_o[i], 16'(gca[i]));
        check($sformatf("gcnt_b[%0d]", i), gcb_o[i], 16'(gcb[i]));
        if (ea && gca[i] < 65535) gca[i]++;
        if (eb && gcb[i] < 65535) gcb[i]++;
`endif
        hsa[i] = ea;
        hsb[i] = eb;
        if (hl[i] > 0) begin
            hl[i]--;
        end else if (ea || eb) begin
            hl[i]  = hc[i];
            md[i]  = ea ? a_d[i] : b_d[i];
            ms[i]  = ea ? 2'b01 : 2'b10;
            fav[i] = ea;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) model_check(i);
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(bit av, logic [7:0] ad, bit bv, logic [7:0] bd);
        for (int i = 0; i < 2; i++) begin
            a_v[i] = av;
            a_d[i] = ad;
            b_v[i] = bv;
            b_d[i] = bd;
        end
    endtask

    initial begin
        int pulses;
        hc[0] = 2;
        hc[1] = 1;
        model_reset();
        set_all(1'b0, 8'h00, 1'b0, 8'h00);

        // reset state, with A requesting during reset
        #2;
        a_v[0] = 1'b1;
        #10;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_dp[%0d]", i), 16'(dp[i]), 16'h0);
            check($sformatf("rst_src[%0d]", i), 16'(src[i]), 16'h0);
            check($sformatf("rst_busy[%0d]", i), 16'(bsy[i]), 16'h0);
            check($sformatf("rst_ar[%0d]", i), 16'(ar[i]), 16'h0);
            check($sformatf("rst_br[%0d]", i), 16'(br[i]), 16'h0);
        end
        a_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // A alone
        set_all(1'b1, 8'h02, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            cycle();
            for (int i = 0; i < 2; i++) if (hsa[i]) a_v[i] = 1'b0;
        end

        // both requesting continuously
        set_all(1'b1, 8'h11, 1'b1, 8'h22);
        for (int k = 0; k < 12; k++) cycle();

        // no requests
        set_all(1'b0, 8'h00, 1'b0, 8'h00);
        for (int k = 0; k < 20; k++) cycle();

        // continuous B; HOLD_CYCLES=1 instance pulses every 2nd cycle
        set_all(1'b0, 8'h00, 1'b1, 8'h5A);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (hsb[1]) pulses++;
        end
        check("b_pulses_h1", 16'(pulses), 16'd4);

        // reset during the first HOLD cycle
        set_all(1'b0, 8'h00, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) cycle();
        set_all(1'b1, 8'hFF, 1'b0, 8'h00);
        cycle();
        set_all(1'b0, 8'h00, 1'b0, 8'h00);
        check("mid_hold_dp", 16'(dp[0]), 16'h00FF);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("async_dp[%0d]", i), 16'(dp[i]), 16'h0);
            check($sformatf("async_src[%0d]", i), 16'(src[i]), 16'h0);
            check($sformatf("async_busy[%0d]", i), 16'(bsy[i]), 16'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_all(1'b1, 8'h33, 1'b1, 8'h44);
        cycle();
        check("ptr_after_rst", {15'd0, hsa[0]}, 16'd1);
        for (int i = 0; i < 2; i++) begin
            if (hsa[i]) a_v[i] = 1'b0;
            if (hsb[i]) b_v[i] = 1'b0;
        end

        // random traffic obeying the hold-until-handshake rule
        for (int k = 0; k < 400; k++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (hsa[i]) a_v[i] = 1'b0;
                if (hsb[i]) b_v[i] = 1'b0;
                if (!a_v[i] && ($urandom % 3) == 0) begin
                    a_v[i] = 1'b1;
                    a_d[i] = 8'($urandom);
                end
                if (!b_v[i] && ($urandom % 3) == 0) begin
                    b_v[i] = 1'b1;
                    b_d[i] = 8'($urandom);
                end
            end
        end

`ifdef RACE_ARB_GRANT_CNT_EN
        // counter saturation
        set_all(1'b0, 8'h00, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) cycle();
        force dut.cnt_a_q = 16'hFFFE;
        #1;
        release dut.cnt_a_q;
        gca[0] = 65534;
        a_v[0] = 1'b1;
        a_d[0] = 8'h77;
        for (int k = 0; k < 9; k++) cycle();
        check("gcnt_sat", gca_o[0], 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
